// File: rtl/ex_stage_pkg.sv
// Shared types and constants for the execute stage: ALUOp classes, funct
// codes, ALU-control and forward-select enums, and the EX/MEM payload.
package ex_stage_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned ALUOP_W = 2;

  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [ALUOP_W-1:0] ALUOP_ORI   = 2'b11;

  localparam logic [FUNCT_W-1:0] FUNCT_ADD = 6'b100000;
  localparam logic [FUNCT_W-1:0] FUNCT_SUB = 6'b100010;
  localparam logic [FUNCT_W-1:0] FUNCT_AND = 6'b100100;
  localparam logic [FUNCT_W-1:0] FUNCT_OR  = 6'b100101;
  localparam logic [FUNCT_W-1:0] FUNCT_NOR = 6'b100111;
  localparam logic [FUNCT_W-1:0] FUNCT_SLT = 6'b101010;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_NOR,
    ALU_SLT
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    FWD_REG,
    FWD_EXMEM,
    FWD_MEMWB
  } fwd_sel_e;

  typedef struct packed {
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] store_data;
    logic [REG_W-1:0]  dest_reg;
    logic              zero;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
    logic              reg_write;
  } exmem_t;

  // Map the ALUOp class (and funct for R-type) onto an ALU operation.
  function automatic alu_ctrl_e alu_decode(input logic [ALUOP_W-1:0] aluop,
                                           input logic [FUNCT_W-1:0] funct);
    alu_ctrl_e ctrl;
    ctrl = ALU_ADD;
    case (aluop)
      ALUOP_ADD: ctrl = ALU_ADD;
      ALUOP_SUB: ctrl = ALU_SUB;
      ALUOP_ORI: ctrl = ALU_OR;
      default: begin
        case (funct)
          FUNCT_SUB: ctrl = ALU_SUB;
          FUNCT_AND: ctrl = ALU_AND;
          FUNCT_OR:  ctrl = ALU_OR;
          FUNCT_NOR: ctrl = ALU_NOR;
          FUNCT_SLT: ctrl = ALU_SLT;
          default:   ctrl = ALU_ADD;
        endcase
      end
    endcase
    return ctrl;
  endfunction

  // Pick the forwarding source for one source register; EX/MEM is younger
  // and wins over MEM/WB, and register 0 is never forwarded.
  function automatic fwd_sel_e fwd_select(input logic [REG_W-1:0] src,
                                          input logic             exmem_we,
                                          input logic [REG_W-1:0] exmem_rd,
                                          input logic             memwb_we,
                                          input logic [REG_W-1:0] memwb_rd);
    fwd_sel_e sel;
    sel = FWD_REG;
    if (src != '0) begin
      if (exmem_we && (exmem_rd == src)) begin
        sel = FWD_EXMEM;
      end else if (memwb_we && (memwb_rd == src)) begin
        sel = FWD_MEMWB;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/ex_alu.sv
// Combinational 32-bit ALU for the execute stage; wraps on overflow.
module ex_alu
  import ex_stage_pkg::*;
(
  input  alu_ctrl_e          i_ctrl,
  input  logic [DATA_W-1:0]  i_a,
  input  logic [DATA_W-1:0]  i_b,
  output logic [DATA_W-1:0]  o_result_c
);

  // Operation select.
  always_comb begin
    o_result_c = i_a + i_b;
    case (i_ctrl)
      ALU_ADD: o_result_c = i_a + i_b;
      ALU_SUB: o_result_c = i_a - i_b;
      ALU_AND: o_result_c = i_a & i_b;
      ALU_OR:  o_result_c = i_a | i_b;
      ALU_NOR: o_result_c = ~(i_a | i_b);
      ALU_SLT: o_result_c = DATA_W'($signed(i_a) < $signed(i_b));
      default: o_result_c = i_a + i_b;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage of the 5-stage MIPS pipeline with its EX/MEM register.
// Optional feature macro: FORWARD_EN enables EX/MEM and MEM/WB operand
// forwarding; without it operands come straight from read1/read2.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              stall,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic              Regdst,
  input  logic              MemRead,
  input  logic              MemtoReg,
  input  logic              MemWrite,
  input  logic              ALUsrc,
  input  logic              RegWrite,
  input  logic [1:0]        ALUOp,
  input  logic [31:0]       Immediate,
  input  logic [31:0]       read1,
  input  logic [31:0]       read2,
  input  logic              wb_RegWrite,
  input  logic [4:0]        wb_rd,
  input  logic [31:0]       wb_data,
  output logic [31:0]       alu_result,
  output logic [31:0]       store_data,
  output logic [4:0]        dest_reg,
  output logic              zero,
  output logic              MemReadout,
  output logic              MemWriteout,
  output logic              MemtoRegout,
  output logic              RegWriteout
);

  exmem_t            r_exmem;
  exmem_t            w_next;
  fwd_sel_e          w_fwd_a_sel;
  fwd_sel_e          w_fwd_b_sel;
  logic [DATA_W-1:0] w_op_a;
  logic [DATA_W-1:0] w_rt_val;
  logic [DATA_W-1:0] w_op_b;
  alu_ctrl_e         w_alu_ctrl;
  logic [DATA_W-1:0] w_alu_result;

`ifdef FORWARD_EN
  // Forward-source selection against the held EX/MEM contents and MEM/WB.
  always_comb begin
    w_fwd_a_sel = fwd_select(rs, r_exmem.reg_write, r_exmem.dest_reg,
                             wb_RegWrite, wb_rd);
    w_fwd_b_sel = fwd_select(rt, r_exmem.reg_write, r_exmem.dest_reg,
                             wb_RegWrite, wb_rd);
  end
`else
  logic w_unused_wb;

  // Without forwarding the hazard unit stalls on every RAW; wb_* unused.
  always_comb begin
    w_fwd_a_sel = FWD_REG;
    w_fwd_b_sel = FWD_REG;
    w_unused_wb = ^{wb_RegWrite, wb_rd, wb_data};
  end
`endif

  // Forwarding muxes for operand A and the rt value.
  always_comb begin
    w_op_a   = read1;
    w_rt_val = read2;
    case (w_fwd_a_sel)
      FWD_EXMEM: w_op_a = r_exmem.alu_result;
      FWD_MEMWB: w_op_a = wb_data;
      default:   w_op_a = read1;
    endcase
    case (w_fwd_b_sel)
      FWD_EXMEM: w_rt_val = r_exmem.alu_result;
      FWD_MEMWB: w_rt_val = wb_data;
      default:   w_rt_val = read2;
    endcase
  end

  // Operand B: ori takes the zero-extended low immediate half.
  always_comb begin
    w_alu_ctrl = alu_decode(ALUOp, Immediate[FUNCT_W-1:0]);
    if (ALUOp == ALUOP_ORI) begin
      w_op_b = {16'h0000, Immediate[15:0]};
    end else if (ALUsrc) begin
      w_op_b = Immediate;
    end else begin
      w_op_b = w_rt_val;
    end
  end

  ex_alu u_alu (
    .i_ctrl     (w_alu_ctrl),
    .i_a        (w_op_a),
    .i_b        (w_op_b),
    .o_result_c (w_alu_result)
  );

  // Next EX/MEM payload; a flush turns it into a bubble.
  always_comb begin
    w_next.alu_result = w_alu_result;
    w_next.store_data = w_rt_val;
    w_next.dest_reg   = Regdst ? rd : rt;
    w_next.zero       = (w_alu_result == '0);
    w_next.mem_read   = MemRead;
    w_next.mem_write  = MemWrite;
    w_next.mem_to_reg = MemtoReg;
    w_next.reg_write  = RegWrite;
    if (flush) begin
      w_next.mem_read   = 1'b0;
      w_next.mem_write  = 1'b0;
      w_next.mem_to_reg = 1'b0;
      w_next.reg_write  = 1'b0;
    end
  end

  // EX/MEM register: flush overrides stall, stall holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_exmem <= '0;
    end else if (flush || !stall) begin
      r_exmem <= w_next;
    end
  end

  assign alu_result  = r_exmem.alu_result;
  assign store_data  = r_exmem.store_data;
  assign dest_reg    = r_exmem.dest_reg;
  assign zero        = r_exmem.zero;
  assign MemReadout  = r_exmem.mem_read;
  assign MemWriteout = r_exmem.mem_write;
  assign MemtoRegout = r_exmem.mem_to_reg;
  assign RegWriteout = r_exmem.reg_write;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: driver pushes expected EX/MEM contents from
// a reference model; an independent monitor pops and compares after each edge.
module tb_ex_stage;

`ifdef FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk, rst_n, flush, stall;
  logic [4:0]  rs, rt, rd;
  logic        Regdst, MemRead, MemtoReg, MemWrite, ALUsrc, RegWrite;
  logic [1:0]  ALUOp;
  logic [31:0] Immediate, read1, read2;
  logic        wb_RegWrite;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] alu_result, store_data;
  logic [4:0]  dest_reg;
  logic        zero, MemReadout, MemWriteout, MemtoRegout, RegWriteout;

  ex_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .stall(stall),
    .rs(rs), .rt(rt), .rd(rd),
    .Regdst(Regdst), .MemRead(MemRead), .MemtoReg(MemtoReg),
    .MemWrite(MemWrite), .ALUsrc(ALUsrc), .RegWrite(RegWrite),
    .ALUOp(ALUOp), .Immediate(Immediate), .read1(read1), .read2(read2),
    .wb_RegWrite(wb_RegWrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .alu_result(alu_result), .store_data(store_data), .dest_reg(dest_reg),
    .zero(zero), .MemReadout(MemReadout), .MemWriteout(MemWriteout),
    .MemtoRegout(MemtoRegout), .RegWriteout(RegWriteout)
  );

  typedef struct {
    bit        rst_n, async_rst, flush, stall;
    bit [4:0]  rs, rt, rd;
    bit        regdst, memread, memtoreg, memwrite, alusrc, regwrite;
    bit [1:0]  aluop;
    bit [31:0] imm, r1, r2;
    bit        wb_we;
    bit [4:0]  wb_rd;
    bit [31:0] wb_data;
  } stim_t;

  typedef struct {
    bit [31:0] alu, store;
    bit [4:0]  dest;
    bit        zero, mr, mw, mtr, rw, known;
    string     tag;
  } exp_t;

  exp_t q[$];
  exp_t m;
  int   n_pass, n_total;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Operand value a source register sees, from the model's register state.
  function automatic bit [31:0] fwd_val(input bit [4:0] r, input bit [31:0] regval,
                                        input stim_t s);
    if (!FWD || r == 5'd0) return regval;
    if (m.rw && m.dest == r) return m.alu;
    if (s.wb_we && s.wb_rd == r) return s.wb_data;
    return regval;
  endfunction

  function automatic bit [31:0] alu_model(input stim_t s, input bit [31:0] a,
                                          input bit [31:0] b);
    bit [5:0] f;
    f = s.imm[5:0];
    case (s.aluop)
      2'd0: return a + b;
      2'd1: return a - b;
      2'd3: return a | {16'h0, s.imm[15:0]};
      default: begin
        case (f)
          6'h22: return a - b;
          6'h24: return a & b;
          6'h25: return a | b;
          6'h27: return ~(a | b);
          6'h2a: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          default: return a + b;
        endcase
      end
    endcase
  endfunction

  function automatic stim_t nop();
    stim_t s;
    s = '{default: '0};
    s.rst_n = 1'b1;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    bit [31:0] r;
    bit [5:0] fl[7];
    fl = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2a, 6'h03};
    s = nop();
    s.flush = ($urandom_range(0, 9) == 0);
    s.stall = ($urandom_range(0, 7) == 0);
    s.rs = 5'($urandom_range(0, 3));
    s.rt = 5'($urandom_range(0, 3));
    s.rd = 5'($urandom_range(0, 3));
    s.regdst = 1'($urandom_range(0, 1));
    s.memread = 1'($urandom_range(0, 1));
    s.memtoreg = 1'($urandom_range(0, 1));
    s.memwrite = 1'($urandom_range(0, 1));
    s.regwrite = ($urandom_range(0, 3) != 0);
    s.aluop = 2'($urandom_range(0, 3));
    s.alusrc = (s.aluop == 2'd3) ? 1'b1 : 1'($urandom_range(0, 1));
    r = $urandom();
    s.imm = (s.aluop == 2'd2) ? {r[31:6], fl[$urandom_range(0, 6)]} : r;
    s.r1 = $urandom();
    s.r2 = ($urandom_range(0, 3) == 0) ? s.r1 : $urandom();
    s.wb_we = 1'($urandom_range(0, 1));
    s.wb_rd = 5'($urandom_range(0, 3));
    s.wb_data = $urandom();
    return s;
  endfunction

  // Drive one cycle of ID/EX inputs and queue the expected EX/MEM state.
  task automatic step(input stim_t s, input string tag);
    bit [31:0] a, rtv, b, res;
    @(negedge clk);
    flush = s.flush; stall = s.stall; rs = s.rs; rt = s.rt; rd = s.rd;
    Regdst = s.regdst; MemRead = s.memread; MemtoReg = s.memtoreg;
    MemWrite = s.memwrite; ALUsrc = s.alusrc; RegWrite = s.regwrite;
    ALUOp = s.aluop; Immediate = s.imm; read1 = s.r1; read2 = s.r2;
    wb_RegWrite = s.wb_we; wb_rd = s.wb_rd; wb_data = s.wb_data;
    if (!s.rst_n) begin
      rst_n = 1'b0;
      if (s.async_rst) begin
        #1;
        chk({tag, ".async.alu"}, alu_result, 32'd0);
        chk({tag, ".async.store"}, store_data, 32'd0);
        chk({tag, ".async.dest"}, 32'(dest_reg), 32'd0);
        chk({tag, ".async.ctl"}, 32'({zero, MemReadout, MemWriteout, MemtoRegout, RegWriteout}), 32'd0);
      end
      m = '{default: '0};
      m.known = 1'b1;
    end else begin
      rst_n = 1'b1;
      a   = fwd_val(s.rs, s.r1, s);
      rtv = fwd_val(s.rt, s.r2, s);
      b   = s.alusrc ? s.imm : rtv;
      res = alu_model(s, a, b);
      if (s.flush || !s.stall) begin
        m.alu = res; m.store = rtv; m.dest = s.regdst ? s.rd : s.rt;
        m.zero = (res == 32'd0);
        m.mr = s.memread; m.mw = s.memwrite; m.mtr = s.memtoreg; m.rw = s.regwrite;
        m.known = 1'b1;
        if (s.flush) begin
          m.mr = 1'b0; m.mw = 1'b0; m.mtr = 1'b0; m.rw = 1'b0; m.known = 1'b0;
        end
      end
    end
    m.tag = tag;
    q.push_back(m);
  endtask

  // Monitor: compare DUT outputs against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk({e.tag, ".MemRead"}, 32'(MemReadout), 32'(e.mr));
        chk({e.tag, ".MemWrite"}, 32'(MemWriteout), 32'(e.mw));
        chk({e.tag, ".MemtoReg"}, 32'(MemtoRegout), 32'(e.mtr));
        chk({e.tag, ".RegWrite"}, 32'(RegWriteout), 32'(e.rw));
        if (e.known) begin
          chk({e.tag, ".alu"}, alu_result, e.alu);
          chk({e.tag, ".store"}, store_data, e.store);
          chk({e.tag, ".dest"}, 32'(dest_reg), 32'(e.dest));
          chk({e.tag, ".zero"}, 32'(zero), 32'(e.zero));
        end
      end
    end
  end

  initial begin
    stim_t s;
    n_pass = 0; n_total = 0;
    m = '{default: '0};
    rst_n = 1'b0;
    s = rand_stim(); s.rst_n = 1'b0; s.async_rst = 1'b1; step(s, "reset0");
    s = rand_stim(); s.rst_n = 1'b0; step(s, "reset1");

    s = nop(); s.r1 = 32'd3; s.r2 = 32'd4; s.regwrite = 1; s.regdst = 1; s.rd = 5'd1;
    step(s, "add3p4");
    s = nop(); s.rs = 5'd3; s.rt = 5'd4; s.r1 = 32'd5; s.r2 = 32'd6;
    s.regwrite = 1; s.regdst = 1; s.rd = 5'd1; step(s, "add5p6");
    s = nop(); s.aluop = 2'd2; s.imm = 32'h22; s.rs = 5'd1; s.rt = 5'd5;
    s.r1 = 32'd0; s.r2 = 32'd1; s.regdst = 1; s.rd = 5'd3; step(s, "exmem_fwd");

    s = nop(); s.r1 = 32'd4; s.r2 = 32'd5; s.regwrite = 1; s.regdst = 1; s.rd = 5'd2;
    step(s, "set_r2");
    s = nop(); s.rs = 5'd2; s.wb_we = 1; s.wb_rd = 5'd2; s.wb_data = 32'd4;
    step(s, "prio");
    s = nop(); s.r1 = 32'd7; s.regwrite = 1; s.regdst = 1; s.rd = 5'd0; step(s, "wr_r0");
    s = nop(); s.rs = 5'd0; s.r1 = 32'd3; s.wb_we = 1; s.wb_rd = 5'd0; s.wb_data = 32'd55;
    step(s, "r0_nofwd");

    s = nop(); s.aluop = 2'd2; s.imm = 32'h2A; s.rs = 5'd10; s.rt = 5'd11;
    s.r1 = 32'hFFFF_FFFF; s.r2 = 32'd1; step(s, "slt");
    s = nop(); s.aluop = 2'd2; s.imm = 32'h27; s.rs = 5'd10; s.rt = 5'd11; step(s, "nor");
    s = nop(); s.aluop = 2'd1; s.r1 = 32'd5; s.r2 = 32'd5; step(s, "sub_zero");
    s = nop(); s.aluop = 2'd3; s.alusrc = 1; s.imm = 32'hFFFF_8001; s.r1 = 32'h0001_0000;
    step(s, "ori");

    s = nop(); s.rs = 5'd12; s.rt = 5'd13; s.memread = 1; s.memtoreg = 1; s.regwrite = 1;
    s.alusrc = 1; s.imm = 32'd4; s.r1 = 32'h200; step(s, "lw");
    s = rand_stim(); s.flush = 0; s.stall = 1; step(s, "stall_hold");
    s = nop(); s.memwrite = 1; s.alusrc = 1; s.imm = 32'd4; s.r1 = 32'h300;
    s.rs = 5'd8; s.rt = 5'd9; s.r2 = 32'h55; step(s, "sw");
    s.regwrite = 1; s.flush = 1; s.stall = 1; step(s, "flush_stall");

    s = nop(); s.memwrite = 1; s.alusrc = 1; s.imm = 32'd8; s.rs = 5'd6; s.rt = 5'd7;
    s.r1 = 32'h100; s.wb_we = 1; s.wb_rd = 5'd7; s.wb_data = 32'hDEADBEEF;
    step(s, "store_fwd");

    s = rand_stim(); s.rst_n = 1'b0; s.async_rst = 1'b1; step(s, "midreset");

    for (int i = 0; i < 400; i++) begin
      s = rand_stim();
      if ($urandom_range(0, 59) == 0) begin
        s.rst_n = 1'b0; s.async_rst = 1'b1;
      end
      step(s, $sformatf("rnd%0d", i));
    end

    @(posedge clk);
    #2;
    chk("drain", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
